// File: rtl/vmicro16_apb_arbiter_pkg.sv
// Shared constants for the vmicro16 APB arbiter: FSM encodings, forced-completion data and index-width helper.
package vmicro16_apb_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_SETUP  = 2'd1,
        ARB_ACCESS = 2'd2
    } arb_state_t;

    localparam logic [15:0] ARB_ERR_DATA = 16'hDEAD;

    // A single master still needs a 1-bit index so grant_id never collapses to zero width.
    function automatic int arb_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vmicro16_apb_arbiter_if.sv
// APB bundle carrying PORTS side-by-side APB links; PORTS=1 gives the plain shared bus.
interface vmicro16_apb_arbiter_if #(
    parameter int PORTS = 1,
    parameter int AW    = 20,
    parameter int DW    = 16
);
    logic [PORTS*AW-1:0] PADDR;
    logic [PORTS-1:0]    PWRITE;
    logic [PORTS-1:0]    PSEL;
    logic [PORTS-1:0]    PENABLE;
    logic [PORTS*DW-1:0] PWDATA;
    logic [PORTS*DW-1:0] PRDATA;
    logic [PORTS-1:0]    PREADY;

    modport master (output PADDR, PWRITE, PSEL, PENABLE, PWDATA, input PRDATA, PREADY);
    modport slave  (input PADDR, PWRITE, PSEL, PENABLE, PWDATA, output PRDATA, PREADY);
endinterface

// File: rtl/vmicro16_rr_picker.sv
// Round-robin pick: first set request after 'last', wrapping; purely combinational.
module vmicro16_rr_picker #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic          valid,
    output logic [IW-1:0] grant
);
    int idx;

    // Scan the farthest offset first so the nearest requester after 'last' overwrites it.
    always_comb begin
        valid = 1'b0;
        grant = '0;
        idx   = 0;
        for (int i = N; i >= 1; i--) begin
            idx = (int'(last) + i) % N;
            if (req[idx]) begin
                valid = 1'b1;
                grant = IW'(idx);
            end
        end
    end
endmodule

// File: rtl/vmicro16_apb_arbiter.sv
// Round-robin APB arbiter: one core master at a time onto the shared bus; zero-wait access completes 2 cycles after IDLE sampling.
// Slave wait states stretch ACCESS; a master dropping PSEL aborts without PREADY.
// VMICRO16_APB_ARB_TIMEOUT_EN adds a forced completion (0xDEAD, timeout_err) after TIMEOUT_CYCLES stalled ACCESS cycles.
module vmicro16_apb_arbiter
    import vmicro16_apb_arbiter_pkg::*;
#(
    parameter int MASTER_PORTS   = 4,
    parameter int BUS_WIDTH      = 20,
    parameter int DATA_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                                  clk,
    input  logic                                  reset,
    vmicro16_apb_arbiter_if.slave                 s,
    vmicro16_apb_arbiter_if.master                m,
    output logic [arb_idx_w(MASTER_PORTS)-1:0]    grant_id,
    output logic                                  busy,
    output logic                                  timeout_err
);
    localparam int IW = arb_idx_w(MASTER_PORTS);

    arb_state_t    state, state_nx;
    logic [IW-1:0] grant, grant_nx, last, last_nx, pick_idx;
    logic          pick_vld, req_held, tmo;

    vmicro16_rr_picker #(.N(MASTER_PORTS), .IW(IW)) u_picker (
        .req   (s.PSEL),
        .last  (last),
        .valid (pick_vld),
        .grant (pick_idx)
    );

    assign req_held = s.PSEL[grant];

`ifdef VMICRO16_APB_ARB_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CW-1:0] tmo_cnt;

    // Held at zero outside ACCESS, so each ACCESS entry starts counting from zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            tmo_cnt <= '0;
        else if (state != ARB_ACCESS)
            tmo_cnt <= '0;
        else if (!m.PREADY)
            tmo_cnt <= tmo_cnt + 1'b1;
    end

    assign tmo = (state == ARB_ACCESS) && req_held && !m.PREADY
                 && (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
    assign tmo = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ARB_IDLE;
            grant <= '0;
            last  <= IW'(MASTER_PORTS - 1);
        end else begin
            state <= state_nx;
            grant <= grant_nx;
            last  <= last_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        grant_nx    = grant;
        last_nx     = last;
        m.PSEL      = 1'b0;
        m.PENABLE   = 1'b0;
        m.PADDR     = '0;
        m.PWRITE    = 1'b0;
        m.PWDATA    = '0;
        s.PREADY    = '0;
        s.PRDATA    = '0;
        timeout_err = 1'b0;

        // Address/data only leave the arbiter while a transfer is in flight.
        if (state != ARB_IDLE) begin
            m.PADDR  = s.PADDR[grant*BUS_WIDTH +: BUS_WIDTH];
            m.PWRITE = s.PWRITE[grant];
            m.PWDATA = s.PWDATA[grant*DATA_WIDTH +: DATA_WIDTH];
        end

        case (state)
            ARB_IDLE: begin
                if (pick_vld) begin
                    grant_nx = pick_idx;
                    state_nx = ARB_SETUP;
                end
            end
            ARB_SETUP: begin
                m.PSEL   = 1'b1;
                state_nx = req_held ? ARB_ACCESS : ARB_IDLE;
            end
            ARB_ACCESS: begin
                m.PSEL    = 1'b1;
                m.PENABLE = 1'b1;
                if (!req_held) begin
                    state_nx = ARB_IDLE;
                end else if (m.PREADY || tmo) begin
                    s.PREADY[grant] = 1'b1;
                    s.PRDATA[grant*DATA_WIDTH +: DATA_WIDTH] =
                        m.PREADY ? m.PRDATA : DATA_WIDTH'(ARB_ERR_DATA);
                    timeout_err = tmo;
                    last_nx     = grant;
                    state_nx    = ARB_IDLE;
                end
            end
            default: state_nx = ARB_IDLE;
        endcase
    end

    assign grant_id = grant;
    assign busy     = (state != ARB_IDLE);
endmodule

// File: tb/tb_vmicro16_apb_arbiter.sv
// Directed + randomized bench for the APB arbiter, checked against a transaction-level round-robin model.
module tb_vmicro16_apb_arbiter;
    localparam int N   = 4;
    localparam int AW  = 20;
    localparam int DW  = 16;
    localparam int TMO = 4;
`ifdef VMICRO16_APB_ARB_TIMEOUT_EN
    localparam bit TMO_ON = 1'b1;
`else
    localparam bit TMO_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    grant_id;
    logic          busy, timeout_err;
    int            vectors = 0, miscompares = 0, cyc = 0;
    logic [N-1:0]  req;
    logic [AW-1:0] addr  [N];
    logic [DW-1:0] wdata [N];
    logic [N-1:0]  wr;
    int            model_last;

    vmicro16_apb_arbiter_if #(.PORTS(N), .AW(AW), .DW(DW)) s_bus ();
    vmicro16_apb_arbiter_if #(.PORTS(1), .AW(AW), .DW(DW)) m_bus ();

    vmicro16_apb_arbiter #(
        .MASTER_PORTS(N), .BUS_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .reset(reset), .s(s_bus.slave), .m(m_bus.master),
        .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            s_bus.PADDR[i*AW +: AW]  = addr[i];
            s_bus.PWDATA[i*DW +: DW] = wdata[i];
        end
        s_bus.PWRITE  = wr;
        s_bus.PSEL    = req;
        s_bus.PENABLE = N'($urandom);
    endtask

    task automatic randomize_masters();
        for (int i = 0; i < N; i++) begin
            addr[i]  = AW'($urandom);
            wdata[i] = DW'($urandom);
            wr[i]    = 1'($urandom_range(0, 1));
        end
    endtask

    // Nearest requester by wrap-around distance from the master after the last one served.
    function automatic int model_pick(input logic [N-1:0] r, input int last);
        int best, bestd, d;
        best  = -1;
        bestd = N;
        for (int i = 0; i < N; i++) begin
            if (r[i]) begin
                d = (i - last - 1 + 2 * N) % N;
                if (d < bestd) begin
                    bestd = d;
                    best  = i;
                end
            end
        end
        return best;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, ".paddr"},   m_bus.PADDR, 0);
        chk({tag, ".pwrite"},  m_bus.PWRITE, 0);
        chk({tag, ".psel"},    m_bus.PSEL, 0);
        chk({tag, ".penable"}, m_bus.PENABLE, 0);
        chk({tag, ".pwdata"},  m_bus.PWDATA, 0);
        chk({tag, ".s_pready"}, s_bus.PREADY, 0);
        chk({tag, ".s_prdata"}, s_bus.PRDATA, 0);
        chk({tag, ".busy"},    busy, 0);
        chk({tag, ".tmo_err"}, timeout_err, 0);
        chk({tag, ".grant_id"}, grant_id, 0);
    endtask

    // Entry and exit: 1 ns after the edge that opens an IDLE cycle, requests already driven.
    task automatic run_txn(input string tag, input int waits, input logic [DW-1:0] rd, output int done_cyc);
        int            g;
        bit            fin, ready, forced;
        logic [N-1:0]  exp_p;
        logic [N*DW-1:0] exp_rd;
        g        = model_pick(req, model_last);
        done_cyc = -1;
        fin      = 1'b0;
        #4;
        chk({tag, ".idle_busy"},   busy, 0);
        chk({tag, ".idle_psel"},   m_bus.PSEL, 0);
        chk({tag, ".idle_pready"}, s_bus.PREADY, 0);
        tick();
        m_bus.PREADY = 1'b0;
        #4;
        chk({tag, ".setup_psel"},    m_bus.PSEL, 1);
        chk({tag, ".setup_penable"}, m_bus.PENABLE, 0);
        chk({tag, ".setup_grant"},   grant_id, g);
        chk({tag, ".setup_paddr"},   m_bus.PADDR, addr[g]);
        chk({tag, ".setup_pwrite"},  m_bus.PWRITE, wr[g]);
        chk({tag, ".setup_pwdata"},  m_bus.PWDATA, wdata[g]);
        chk({tag, ".setup_pready"},  s_bus.PREADY, 0);
        for (int a = 1; a <= 64 && !fin; a++) begin
            tick();
            ready  = (a == waits + 1);
            forced = TMO_ON && !ready && (a == TMO);
            m_bus.PREADY = ready;
            m_bus.PRDATA = ready ? rd : DW'($urandom);
            #4;
            exp_p  = '0;
            exp_rd = '0;
            if (ready || forced) exp_p[g] = 1'b1;
            if (ready) exp_rd[g*DW +: DW] = rd;
            else if (forced) exp_rd[g*DW +: DW] = 16'hDEAD;
            chk({tag, ".acc_psel"},    m_bus.PSEL, 1);
            chk({tag, ".acc_penable"}, m_bus.PENABLE, 1);
            chk({tag, ".acc_paddr"},   m_bus.PADDR, addr[g]);
            chk({tag, ".acc_pwdata"},  m_bus.PWDATA, wdata[g]);
            chk({tag, ".acc_pready"},  s_bus.PREADY, exp_p);
            chk({tag, ".acc_prdata"},  s_bus.PRDATA, exp_rd);
            chk({tag, ".acc_tmo_err"}, timeout_err, forced);
            if (ready || forced) begin
                fin        = 1'b1;
                done_cyc   = cyc;
                model_last = g;
            end
        end
        chk({tag, ".completed"}, fin, 1);
        tick();
        m_bus.PREADY = 1'b0;
    endtask

    initial begin
        int dc, prev;
        reset = 1'b0;
        randomize_masters();
        req = '1;
        drive();
        m_bus.PREADY = 1'b1;
        m_bus.PRDATA = 16'h5555;
        model_last = N - 1;
        #20;
        chk_all_zero("reset");
        tick();
        m_bus.PREADY = 1'b0;
        reset = 1'b1;

        // All four contend from reset: served 0,1,2,3, three cycles apart.
        prev = 0;
        for (int k = 0; k < N; k++) begin
            run_txn("contend", 0, DW'($urandom), dc);
            if (k > 0) chk("contend.spacing", dc - prev, 3);
            prev = dc;
        end

        req = 4'b0010;
        addr[1] = 20'h00005; wdata[1] = 16'h1234; wr[1] = 1'b1;
        drive();
        run_txn("single_wr", 0, 16'h0000, dc);

        req = 4'b0100; wr[2] = 1'b0; addr[2] = AW'($urandom);
        drive();
        run_txn("wait_rd", 3, 16'hBEEF, dc);

        req = 4'b0001;
        drive();
        run_txn("m0_wr", 0, DW'($urandom), dc);

        // Master 2 wins over 3 then withdraws during SETUP.
        req = 4'b1100;
        drive();
        #4;
        chk("abort.idle_busy", busy, 0);
        tick();
        #4;
        chk("abort.setup_psel", m_bus.PSEL, 1);
        chk("abort.setup_grant", grant_id, model_pick(req, model_last));
        req[2] = 1'b0;
        s_bus.PSEL = req;
        #1;
        chk("abort.setup_pready", s_bus.PREADY, 0);
        tick();
        chk("abort.idle_after", busy, 0);
        chk("abort.no_pready", s_bus.PREADY, 0);
        run_txn("after_abort", 1, DW'($urandom), dc);

        // Reset while a wait-state ACCESS is stalled.
        req = 4'b0100;
        drive();
        tick();
        tick();
        m_bus.PREADY = 1'b0;
        #3;
        chk("rst_mid.in_access", m_bus.PENABLE, 1);
        reset = 1'b0;
        #1;
        chk_all_zero("rst_mid");
        tick();
        tick();
        reset = 1'b1;
        model_last = N - 1;
        req = '1;
        drive();
        run_txn("post_rst", 0, DW'($urandom), dc);

`ifdef VMICRO16_APB_ARB_TIMEOUT_EN
        req = 4'b0010;
        drive();
        run_txn("timeout", 20, DW'($urandom), dc);
        run_txn("after_tmo", 1, DW'($urandom), dc);
`endif

        for (int t = 0; t < 30; t++) begin
            randomize_masters();
            req = N'($urandom_range(1, (1 << N) - 1));
            drive();
            run_txn("rand", $urandom_range(0, 5), DW'($urandom), dc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
